// File: rtl/board_mem_pkg.sv
// Shared constants and types for the battleship board-memory arbiter.
package board_mem_pkg;

    // Default board geometry: 32 rows of 64 cells per player.
    localparam int DEF_ROW_W  = 64;
    localparam int DEF_ADDR_W = 5;

    // Client slots on the arbiter.
    localparam int CLI_VALIDADOR = 0;
    localparam int CLI_COLISOR   = 1;
    localparam int CLI_PONTUACAO = 2;
    localparam int CLI_VGA       = 3;

    // Board RAM index per player.
    localparam int P1 = 0;
    localparam int P2 = 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational one-hot arbiter: round-robin from i_ptr, or fixed priority
// (index 0 highest) when FIXED_PRIO is set. i_ptr is ignored in fixed mode.
module rr_arbiter #(
    parameter int N          = 4,
    parameter bit FIXED_PRIO = 1'b0,
    localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    int             w_j;
    logic [IDX_W-1:0] w_cand;
    logic           w_found;

    // Scan candidates starting at the pointer (or at 0), first requester wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        w_j     = 0;
        w_cand  = '0;
        for (int i = 0; i < N; i++) begin
            w_j = FIXED_PRIO ? i : int'(i_ptr) + i;
            if (w_j >= N) w_j = w_j - N;
            w_cand = IDX_W'(w_j);
            if (!w_found && i_req[w_cand]) begin
                w_found       = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
        o_any = w_found;
    end

endmodule

// File: rtl/board_mem_arbiter.sv
// Arbiter between game-logic engines and the per-player board RAMs.
// A granted owner issues one row read or write per cycle while it holds req;
// a burst limit forces rotation when another engine is waiting.
module board_mem_arbiter
    import board_mem_pkg::*;
#(
    parameter int N_CLIENTS  = 4,
    parameter int N_PLAYERS  = 2,
    parameter int ROW_W      = DEF_ROW_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int MAX_BURST  = 16,
    parameter bit FIXED_PRIO = 1'b0,
    localparam int PSEL_W    = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                          clk,
    input  logic                          resetGeral,
    input  logic [N_CLIENTS-1:0]          req,
    input  logic [N_CLIENTS-1:0]          we,
    input  logic [N_CLIENTS*PSEL_W-1:0]   psel,
    input  logic [N_CLIENTS*ADDR_W-1:0]   addr,
    input  logic [N_CLIENTS*ROW_W-1:0]    wdata,
    output logic [N_CLIENTS-1:0]          gnt,
    output logic [N_CLIENTS-1:0]          rvalid,
    output logic [ROW_W-1:0]              rdata,
    output logic                          err,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [ROW_W-1:0]              mem_wdata,
    output logic [N_PLAYERS-1:0]          mem_wren,
    input  logic [N_PLAYERS*ROW_W-1:0]    mem_rdata
);

    localparam int IDX_W = $clog2(N_CLIENTS);
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t           r_state, w_state_nxt;
    logic [N_CLIENTS-1:0] r_gnt, w_gnt_nxt;
    logic [IDX_W-1:0]     r_owner, w_owner_nxt, r_rr_ptr, w_rr_ptr_nxt, w_owner_inc;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                 r_err;
    logic [N_CLIENTS-1:0] r_rvalid;
    logic [PSEL_W-1:0]    r_rd_psel;
    logic                 r_rd_ok;

    logic [N_CLIENTS-1:0] w_win_gnt;
    logic [IDX_W-1:0]     w_win_idx;
    logic                 w_win_any;
    logic                 w_owned, w_beat, w_o_we, w_psel_ok, w_others;
    logic [PSEL_W-1:0]    w_o_psel;
    logic [ADDR_W-1:0]    w_o_addr;
    logic [ROW_W-1:0]     w_o_wdata;

    rr_arbiter #(
        .N          (N_CLIENTS),
        .FIXED_PRIO (FIXED_PRIO)
    ) u_arb (
        .i_req (req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_win_gnt),
        .o_idx (w_win_idx),
        .o_any (w_win_any)
    );

    // Owner's beat fields, selected by the registered owner index.
    assign w_owned   = (r_state == ST_OWNED);
    assign w_beat    = w_owned & req[r_owner];
    assign w_o_we    = we[r_owner];
    assign w_o_psel  = psel[r_owner*PSEL_W +: PSEL_W];
    assign w_o_addr  = addr[r_owner*ADDR_W +: ADDR_W];
    assign w_o_wdata = wdata[r_owner*ROW_W +: ROW_W];
    assign w_psel_ok = (int'(w_o_psel) < N_PLAYERS);
    assign w_others  = |(req & ~r_gnt);

    assign w_cnt_inc   = (r_cnt == CNT_W'(MAX_BURST)) ? r_cnt : r_cnt + CNT_W'(1);
    assign w_owner_inc = (r_owner == IDX_W'(N_CLIENTS - 1)) ? '0 : r_owner + IDX_W'(1);

    // Next-state: grant from IDLE; release on req drop or exhausted burst under contention.
    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_owner_nxt  = r_owner;
        w_cnt_nxt    = r_cnt;
        w_rr_ptr_nxt = r_rr_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_win_any) begin
                    w_state_nxt = ST_OWNED;
                    w_gnt_nxt   = w_win_gnt;
                    w_owner_nxt = w_win_idx;
                    w_cnt_nxt   = '0;
                end
            end
            ST_OWNED: begin
                if (w_beat) w_cnt_nxt = w_cnt_inc;
                if (!w_beat || (w_cnt_inc == CNT_W'(MAX_BURST) && w_others)) begin
                    w_state_nxt  = ST_IDLE;
                    w_gnt_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_rr_ptr_nxt = w_owner_inc;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM, grant and rotation state.
    always_ff @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            r_state  <= ST_IDLE;
            r_gnt    <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_owner  <= w_owner_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
        end
    end

    // Read-return tracking aligned with the RAM's one-cycle read latency; sticky psel error.
    always_ff @(posedge clk or posedge resetGeral) begin
        if (resetGeral) begin
            r_rvalid  <= '0;
            r_rd_psel <= '0;
            r_rd_ok   <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid  <= (w_beat && !w_o_we) ? r_gnt : '0;
            r_rd_psel <= w_o_psel;
            r_rd_ok   <= w_psel_ok;
            r_err     <= r_err | (w_beat & ~w_psel_ok);
        end
    end

    // RAM-side drive and read-data return; out-of-range players never match p.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wren  = '0;
        rdata     = '0;
        if (w_owned) begin
            mem_addr  = w_o_addr;
            mem_wdata = w_o_wdata;
        end
        for (int p = 0; p < N_PLAYERS; p++) begin
            if (w_beat && w_o_we && (w_o_psel == PSEL_W'(p)))
                mem_wren[p] = 1'b1;
            if ((|r_rvalid) && r_rd_ok && (r_rd_psel == PSEL_W'(p)))
                rdata = mem_rdata[p*ROW_W +: ROW_W];
        end
    end

    assign gnt    = r_gnt;
    assign rvalid = r_rvalid;
    assign err    = r_err;

endmodule

// File: tb/tb_board_mem_arbiter.sv
// Directed bench: cycle-by-cycle vector table on a round-robin instance
// (MAX_BURST=4, 2 players) plus hand sequences on a fixed-priority
// 3-player instance for priority and out-of-range player handling.
module tb_board_mem_arbiter;

    logic         clk;
    logic         resetGeral;

    // Round-robin instance
    logic [3:0]   req, we, psel;
    logic [19:0]  addr;
    logic [255:0] wdata;
    logic [3:0]   gnt, rvalid;
    logic [63:0]  rdata;
    logic         err;
    logic [4:0]   mem_addr;
    logic [63:0]  mem_wdata;
    logic [1:0]   mem_wren;
    logic [127:0] mem_rdata;

    // Fixed-priority instance
    logic [3:0]   fp_req, fp_we;
    logic [7:0]   fp_psel;
    logic [19:0]  fp_addr;
    logic [255:0] fp_wdata;
    logic [3:0]   fp_gnt, fp_rvalid;
    logic [63:0]  fp_rdata;
    logic         fp_err;
    logic [4:0]   fp_mem_addr;
    logic [63:0]  fp_mem_wdata;
    logic [2:0]   fp_mem_wren;
    logic [191:0] fp_mem_rdata;

    int checks = 0;
    int errors = 0;

    board_mem_arbiter #(
        .N_CLIENTS(4), .N_PLAYERS(2), .ROW_W(64), .ADDR_W(5),
        .MAX_BURST(4), .FIXED_PRIO(1'b0)
    ) dut (
        .clk(clk), .resetGeral(resetGeral), .req(req), .we(we), .psel(psel),
        .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .err(err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wren(mem_wren), .mem_rdata(mem_rdata)
    );

    board_mem_arbiter #(
        .N_CLIENTS(4), .N_PLAYERS(3), .ROW_W(64), .ADDR_W(5),
        .MAX_BURST(16), .FIXED_PRIO(1'b1)
    ) dut_fp (
        .clk(clk), .resetGeral(resetGeral), .req(fp_req), .we(fp_we), .psel(fp_psel),
        .addr(fp_addr), .wdata(fp_wdata), .gnt(fp_gnt), .rvalid(fp_rvalid), .rdata(fp_rdata),
        .err(fp_err), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
        .mem_wren(fp_mem_wren), .mem_rdata(fp_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed RAM contents per player for the fixed-priority instance.
    assign fp_mem_rdata = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};

    function automatic logic [63:0] pat(int p, int a);
        return {16'hB0A0, 8'(p), 8'(a), 16'hC0DE, 8'(a), 8'(p)};
    endfunction

    // Board RAM model: synchronous read, reloads a known pattern while in reset.
    logic [63:0] ram [2][32];
    logic [63:0] ram_q [2];
    always @(posedge clk) begin
        if (resetGeral) begin
            for (int p = 0; p < 2; p++)
                for (int a = 0; a < 32; a++)
                    ram[p][a] <= pat(p, a);
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (mem_wren[p]) ram[p][mem_addr] <= mem_wdata;
                ram_q[p] <= ram[p][mem_addr];
            end
        end
    end
    assign mem_rdata = {ram_q[1], ram_q[0]};

    typedef struct {
        logic        rst;
        logic [3:0]  req, we, psel;
        logic [19:0] addr;
        logic [63:0] wd0;
        logic [3:0]  e_gnt;
        logic [1:0]  e_wren;
        logic [4:0]  e_addr;
        logic [3:0]  e_rv;
        logic [63:0] e_rd;
    } vec_t;

    vec_t tv [20];

    function automatic vec_t mk(logic rst, logic [3:0] rq, logic [3:0] w, logic [3:0] ps,
                                logic [19:0] ad, logic [63:0] wd, logic [3:0] eg,
                                logic [1:0] ew, logic [4:0] ea, logic [3:0] erv,
                                logic [63:0] erd);
        vec_t v;
        v.rst = rst; v.req = rq; v.we = w; v.psel = ps; v.addr = ad; v.wd0 = wd;
        v.e_gnt = eg; v.e_wren = ew; v.e_addr = ea; v.e_rv = erv; v.e_rd = erd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] W31 = 64'hFFFF_0000_0000_FFFF;
    localparam logic [19:0] AMIX = {5'd0, 5'd2, 5'd0, 5'd1};

    initial begin
        resetGeral = 1'b1;
        req = '0; we = '0; psel = '0; addr = '0; wdata = '0;
        fp_req = '0; fp_we = '0; fp_psel = '0; fp_addr = '0; fp_wdata = '0;

        //           rst req      we       psel     addr    wd0  gnt      wren   addr  rv       rdata
        tv[0]  = mk(0, 4'b0001, 4'b0000, 4'b0001, 20'd5,  0,   4'b0000, 2'b00, 5'd0,  4'b0000, 0);
        tv[1]  = mk(0, 4'b0001, 4'b0000, 4'b0001, 20'd5,  0,   4'b0001, 2'b00, 5'd5,  4'b0000, 0);
        tv[2]  = mk(0, 4'b0001, 4'b0001, 4'b0000, 20'd31, W31, 4'b0001, 2'b01, 5'd31, 4'b0001, pat(1, 5));
        tv[3]  = mk(0, 4'b0001, 4'b0000, 4'b0000, 20'd31, 0,   4'b0001, 2'b00, 5'd31, 4'b0000, 0);
        tv[4]  = mk(0, 4'b0000, 4'b0000, 4'b0000, 20'd0,  0,   4'b0001, 2'b00, 5'd0,  4'b0001, W31);
        tv[5]  = mk(1, 4'b0000, 4'b0000, 4'b0000, 20'd0,  0,   4'b0000, 2'b00, 5'd0,  4'b0000, 0);
        tv[6]  = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0000, 2'b00, 5'd0,  4'b0000, 0);
        tv[7]  = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0001, 2'b00, 5'd1,  4'b0000, 0);
        tv[8]  = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0001, 2'b00, 5'd1,  4'b0001, pat(0, 1));
        tv[9]  = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0001, 2'b00, 5'd1,  4'b0001, pat(0, 1));
        tv[10] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0001, 2'b00, 5'd1,  4'b0001, pat(0, 1));
        tv[11] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0000, 2'b00, 5'd0,  4'b0001, pat(0, 1));
        tv[12] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0100, 2'b00, 5'd2,  4'b0000, 0);
        tv[13] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0100, 2'b00, 5'd2,  4'b0100, pat(1, 2));
        tv[14] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0100, 2'b00, 5'd2,  4'b0100, pat(1, 2));
        tv[15] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0100, 2'b00, 5'd2,  4'b0100, pat(1, 2));
        tv[16] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0000, 2'b00, 5'd0,  4'b0100, pat(1, 2));
        tv[17] = mk(0, 4'b0101, 4'b0000, 4'b0100, AMIX,   0,   4'b0001, 2'b00, 5'd1,  4'b0000, 0);
        tv[18] = mk(0, 4'b0000, 4'b0000, 4'b0100, AMIX,   0,   4'b0001, 2'b00, 5'd1,  4'b0001, pat(0, 1));
        tv[19] = mk(0, 4'b0000, 4'b0000, 4'b0000, 20'd0,  0,   4'b0000, 2'b00, 5'd0,  4'b0000, 0);

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset gnt", gnt, 0);
        chk("reset rvalid", rvalid, 0);
        chk("reset rdata", rdata, 0);
        chk("reset err", err, 0);
        chk("reset mem_wren", mem_wren, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);

        // Vector table: read, write/readback, round-robin with burst rotation
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            resetGeral = tv[i].rst;
            req = tv[i].req; we = tv[i].we; psel = tv[i].psel;
            addr = tv[i].addr; wdata = {192'h0, tv[i].wd0};
            @(negedge clk);
            chk($sformatf("row%0d gnt", i), gnt, tv[i].e_gnt);
            chk($sformatf("row%0d mem_wren", i), mem_wren, tv[i].e_wren);
            chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].e_addr);
            chk($sformatf("row%0d rvalid", i), rvalid, tv[i].e_rv);
            if (tv[i].e_rv != 0)
                chk($sformatf("row%0d rdata", i), rdata, tv[i].e_rd);
        end

        // Fixed priority: client 1 beats client 3; client 3 only after release
        @(posedge clk); #1 fp_req = 4'b1010;
        @(negedge clk); chk("fp idle gnt", fp_gnt, 4'b0000);
        @(negedge clk); chk("fp grant c1", fp_gnt, 4'b0010);
        repeat (3) @(negedge clk);
        chk("fp hold c1", fp_gnt, 4'b0010);
        @(posedge clk); #1 fp_req = 4'b1000;
        @(negedge clk); chk("fp c1 last cycle", fp_gnt, 4'b0010);
        @(negedge clk); chk("fp idle gap", fp_gnt, 4'b0000);
        @(negedge clk); chk("fp grant c3", fp_gnt, 4'b1000);
        @(posedge clk); #1 fp_req = 4'b0000;
        @(negedge clk);
        @(negedge clk); chk("fp released", fp_gnt, 4'b0000);

        // Out-of-range player: legal read first, then read and write to psel=3
        @(posedge clk); #1;
        fp_req = 4'b0001; fp_we = 4'b0000; fp_psel = 8'h02; fp_addr = 20'd7;
        fp_wdata = {192'h0, 64'hDEAD_BEEF_0123_4567};
        @(negedge clk);
        @(negedge clk);
        chk("fp owner gnt", fp_gnt, 4'b0001);
        chk("fp mem_addr", fp_mem_addr, 5'd7);
        chk("fp read wren", fp_mem_wren, 3'b000);
        @(posedge clk); #1 fp_psel = 8'h03;
        @(negedge clk);
        chk("fp p2 rvalid", fp_rvalid, 4'b0001);
        chk("fp p2 rdata", fp_rdata, 64'h3333_3333_3333_3333);
        chk("fp err clear", fp_err, 1'b0);
        @(posedge clk); #1 fp_we = 4'b0001;
        @(negedge clk);
        chk("fp bad rvalid", fp_rvalid, 4'b0001);
        chk("fp bad rdata", fp_rdata, 64'h0);
        chk("fp err set", fp_err, 1'b1);
        chk("fp bad wren", fp_mem_wren, 3'b000);
        chk("fp mem_wdata", fp_mem_wdata, 64'hDEAD_BEEF_0123_4567);
        @(posedge clk); #1 fp_req = 4'b0000; fp_we = 4'b0000;
        @(negedge clk); chk("fp write no rvalid", fp_rvalid, 4'b0000);
        repeat (3) @(negedge clk);
        chk("fp err sticky", fp_err, 1'b1);

        // Reset mid-burst, one cycle after a read beat
        @(posedge clk); #1;
        req = 4'b0001; we = 4'b0000; psel = 4'b0000; addr = 20'd3; wdata = '0;
        @(negedge clk);
        @(negedge clk); chk("mid gnt", gnt, 4'b0001);
        @(posedge clk); #1 we = 4'b0001; wdata = {192'h0, 64'h1234};
        @(negedge clk);
        chk("mid rvalid", rvalid, 4'b0001);
        chk("mid wren", mem_wren, 2'b01);
        #1 resetGeral = 1'b1;
        #1;
        chk("async gnt", gnt, 0);
        chk("async rvalid", rvalid, 0);
        chk("async wren", mem_wren, 0);
        chk("async mem_addr", mem_addr, 0);
        chk("async fp_err", fp_err, 0);
        @(posedge clk); #1;
        resetGeral = 1'b0; req = '0; we = '0; wdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post-reset rvalid%0d", k), rvalid, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
